// File: rtl/onehot_seq_detector_param_if.sv
// ---------------------------------------------------------------------------
// onehot_seq_detector_param_if
// Purpose : bundles the serial data, control and status signals of the
//           one-hot sequence detector into a single port.
// Signals :
//   x, x_valid   serial data bit and its qualifier (master -> slave)
//   load         latch pattern_in into the detector (master -> slave)
//   pattern_in   new pattern, MSB received first (master -> slave)
//   overlap_en   1 = overlapping matches (master -> slave)
//   state        one-hot match-progress state (slave -> master)
//   z            registered one-cycle match pulse (slave -> master)
//   match_cnt    saturating match counter (slave -> master)
//   state_err    sticky one-hot violation flag (slave -> master)
// Modports: master = stimulus / front-end side, slave = detector side.
// ---------------------------------------------------------------------------
interface onehot_seq_detector_param_if #(
    parameter int PAT_LEN = 4,
    parameter int CNT_W   = 8
);
    logic               x;
    logic               x_valid;
    logic               load;
    logic [PAT_LEN-1:0] pattern_in;
    logic               overlap_en;
    logic [PAT_LEN-1:0] state;
    logic               z;
    logic [CNT_W-1:0]   match_cnt;
    logic               state_err;

    modport master (
        output x, x_valid, load, pattern_in, overlap_en,
        input  state, z, match_cnt, state_err
    );

    modport slave (
        input  x, x_valid, load, pattern_in, overlap_en,
        output state, z, match_cnt, state_err
    );
endinterface

// File: rtl/onehot_seq_detector_param.sv
// ---------------------------------------------------------------------------
// onehot_seq_detector_param
// Purpose : parametrised Mealy-style serial pattern detector with one-hot
//           state encoding. state[k]=1 means the first k pattern bits have
//           been seen. The pattern is runtime-loadable, matching may be
//           overlapping or restart-after-match, and every match produces a
//           registered one-cycle pulse on z plus a saturating count.
// Parameters:
//   PAT_LEN  pattern length (>= 2), also the number of one-hot states
//   PAT_RST  pattern loaded at reset
//   CNT_W    width of match_cnt
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   bus      onehot_seq_detector_param_if.slave (x, x_valid, load,
//            pattern_in, overlap_en in; state, z, match_cnt, state_err out)
// Configuration macro: ONEHOT_CHECK_EN
//   defined   -> state is checked for exactly one bit set every cycle; a
//                violation sets sticky state_err and forces state to S0.
//   undefined -> no checker, state_err is tied low.
// ---------------------------------------------------------------------------
module onehot_seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PAT_RST = 4'b1011,
    parameter int                 CNT_W   = 8
) (
    input logic                        clk,
    input logic                        rst,
    onehot_seq_detector_param_if.slave bus
);

    localparam int                 HIST_W = PAT_LEN - 1;
    localparam logic [PAT_LEN-1:0] S0     = PAT_LEN'(1);
    localparam logic [PAT_LEN-1:0] ONES   = '1;

    logic [PAT_LEN-1:0] state_q, state_d;
    logic [PAT_LEN-1:0] pattern_q, pattern_d;
    logic [HIST_W-1:0]  hist_q, hist_d;
    logic               z_q, z_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [PAT_LEN-1:0] cand;
    logic               full_match;
    logic [PAT_LEN-1:0] adv_state;
    logic [PAT_LEN-1:0] border_state;
    int                 k_idx;
    int                 adv_j;
    int                 border_j;
    logic [PAT_LEN-1:0] mask;
    logic [PAT_LEN-1:0] prefix;

`ifdef ONEHOT_CHECK_EN
    logic err_q, err_d;
    logic onehot_bad;
    int   ones;
`endif

    // Match-progress evaluation.
    // hist_q keeps the last PAT_LEN-1 accepted bits, so {hist_q, x} holds the
    // candidate "matched bits followed by x" in its low k+1 bits. The next
    // state is the longest pattern prefix (shorter than the full pattern)
    // that is a suffix of that candidate. border_j is the longest proper
    // prefix of the pattern that is also its suffix, used after an
    // overlapping full match.
    always_comb begin
        cand       = {hist_q, bus.x};
        full_match = state_q[PAT_LEN-1] && (bus.x == pattern_q[0]);
        k_idx      = 0;
        adv_j      = 0;
        border_j   = 0;
        mask       = '0;
        prefix     = '0;
        for (int i = 0; i < PAT_LEN; i++) begin
            if (state_q[i]) begin
                k_idx = i;
            end
        end
        for (int j = 1; j < PAT_LEN; j++) begin
            mask   = ONES >> (PAT_LEN - j);
            prefix = pattern_q >> (PAT_LEN - j);
            if ((j <= k_idx + 1) && (((prefix ^ cand) & mask) == '0)) begin
                adv_j = j;
            end
            if (((prefix ^ pattern_q) & mask) == '0) begin
                border_j = j;
            end
        end
        adv_state    = S0 << adv_j;
        border_state = S0 << border_j;
    end

`ifdef ONEHOT_CHECK_EN
    // Population count of the state vector; anything other than one set bit
    // is an illegal state.
    always_comb begin
        ones = 0;
        for (int i = 0; i < PAT_LEN; i++) begin
            ones = ones + int'(state_q[i]);
        end
        onehot_bad = (ones != 1);
    end
`endif

    // Next-state selection. Priority: one-hot recovery (when built in),
    // then load, then a valid serial bit. z only pulses for the cycle after
    // a full match; every other path drives it low.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        hist_d    = hist_q;
        z_d       = 1'b0;
        cnt_d     = cnt_q;
`ifdef ONEHOT_CHECK_EN
        err_d     = err_q;
        if (onehot_bad) begin
            state_d = S0;
            hist_d  = '0;
            err_d   = 1'b1;
        end else
`endif
        if (bus.load) begin
            pattern_d = bus.pattern_in;
            state_d   = S0;
            hist_d    = '0;
        end else if (bus.x_valid) begin
            hist_d = cand[HIST_W-1:0];
            if (full_match) begin
                z_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = bus.overlap_en ? border_state : S0;
            end else begin
                state_d = adv_state;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S0;
            pattern_q <= PAT_RST;
            hist_q    <= '0;
            z_q       <= 1'b0;
            cnt_q     <= '0;
`ifdef ONEHOT_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            hist_q    <= hist_d;
            z_q       <= z_d;
            cnt_q     <= cnt_d;
`ifdef ONEHOT_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    assign bus.state     = state_q;
    assign bus.z         = z_q;
    assign bus.match_cnt = cnt_q;
`ifdef ONEHOT_CHECK_EN
    assign bus.state_err = err_q;
`else
    assign bus.state_err = 1'b0;
`endif

endmodule

// File: tb/tb_onehot_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_onehot_seq_detector_param
// Scoreboard bench for onehot_seq_detector_param. Two instances: a 4-bit
// detector with the default 1011 pattern, and a 2-bit detector (pattern 11,
// 2-bit counter) for the back-to-back and saturation behaviour. Each
// stimulus cycle pushes the hand-computed expected outputs for the edge it
// drives; a monitor per instance pops and compares just after that edge.
// ---------------------------------------------------------------------------
module tb_onehot_seq_detector_param;

    localparam logic [3:0] S0 = 4'b0001;
    localparam logic [3:0] S1 = 4'b0010;
    localparam logic [3:0] S2 = 4'b0100;
    localparam logic [3:0] S3 = 4'b1000;
    localparam logic [1:0] T0 = 2'b01;
    localparam logic [1:0] T1 = 2'b10;

    typedef struct {
        string      tag;
        logic [3:0] st;
        logic       z;
        logic [7:0] cnt;
        logic       err;
    } exp4_t;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic       z;
        logic [1:0] cnt;
    } exp2_t;

    logic clk = 1'b0;
    logic rst4;
    logic rst2;
    logic exp_err;
    int   errors = 0;
    int   checks = 0;

    exp4_t q4[$];
    exp2_t q2[$];

    onehot_seq_detector_param_if #(.PAT_LEN(4), .CNT_W(8)) bus4 ();
    onehot_seq_detector_param_if #(.PAT_LEN(2), .CNT_W(2)) bus2 ();

    onehot_seq_detector_param #(.PAT_LEN(4), .PAT_RST(4'b1011), .CNT_W(8)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (bus4)
    );

    onehot_seq_detector_param #(.PAT_LEN(2), .PAT_RST(2'b11), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    always #5 clk = ~clk;

    // Drive one cycle of the 4-bit instance and record what it must show
    // after the next rising edge.
    task automatic applyStimulus(input string tag, input logic r, input logic ld,
                                 input logic xv, input logic xb, input logic [3:0] pin,
                                 input logic [3:0] es, input logic ez,
                                 input logic [7:0] ec, input logic ee);
        @(negedge clk);
        rst4            = r;
        bus4.load       = ld;
        bus4.x_valid    = xv;
        bus4.x          = xb;
        bus4.pattern_in = pin;
        q4.push_back('{tag, es, ez, ec, ee});
    endtask

    task automatic reset4(input string tag);
        applyStimulus(tag, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0000, S0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic bit4(input string tag, input logic xb, input logic [3:0] es,
                        input logic ez, input logic [7:0] ec);
        applyStimulus(tag, 1'b0, 1'b0, 1'b1, xb, 4'b0000, es, ez, ec, exp_err);
    endtask

    task automatic idle4(input string tag, input int n, input logic [3:0] es,
                         input logic [7:0] ec);
        for (int i = 0; i < n; i++) begin
            applyStimulus(tag, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)), 4'b0000,
                          es, 1'b0, ec, exp_err);
        end
    endtask

    task automatic applyStimulus2(input string tag, input logic r, input logic xv,
                                  input logic xb, input logic [1:0] es,
                                  input logic ez, input logic [1:0] ec);
        @(negedge clk);
        rst2         = r;
        bus2.x_valid = xv;
        bus2.x       = xb;
        q2.push_back('{tag, es, ez, ec});
    endtask

    task automatic checkOutput(input exp4_t e);
        checks++;
        if ({bus4.state, bus4.z, bus4.match_cnt, bus4.state_err} !== {e.st, e.z, e.cnt, e.err}) begin
            errors++;
            $display("[TB] FAIL %s: got state=%b z=%b cnt=%0d err=%b, want state=%b z=%b cnt=%0d err=%b",
                     e.tag, bus4.state, bus4.z, bus4.match_cnt, bus4.state_err,
                     e.st, e.z, e.cnt, e.err);
        end
    endtask

    task automatic checkOutput2(input exp2_t e);
        checks++;
        if ({bus2.state, bus2.z, bus2.match_cnt, bus2.state_err} !== {e.st, e.z, e.cnt, 1'b0}) begin
            errors++;
            $display("[TB] FAIL %s: got state=%b z=%b cnt=%0d err=%b, want state=%b z=%b cnt=%0d err=0",
                     e.tag, bus2.state, bus2.z, bus2.match_cnt, bus2.state_err,
                     e.st, e.z, e.cnt);
        end
    endtask

    // Monitors: compare just after each rising edge for which an expectation
    // was queued.
    always @(posedge clk) begin
        #1;
        if (q4.size() > 0) begin
            checkOutput(q4.pop_front());
        end
    end

    always @(posedge clk) begin
        #1;
        if (q2.size() > 0) begin
            checkOutput2(q2.pop_front());
        end
    end

    initial begin
        exp_err         = 1'b0;
        rst4            = 1'b1;
        rst2            = 1'b1;
        bus4.x          = 1'b0;
        bus4.x_valid    = 1'b0;
        bus4.load       = 1'b0;
        bus4.pattern_in = 4'b0000;
        bus4.overlap_en = 1'b1;
        bus2.x          = 1'b0;
        bus2.x_valid    = 1'b0;
        bus2.load       = 1'b0;
        bus2.pattern_in = 2'b00;
        bus2.overlap_en = 1'b1;

        // Basic detection 1011
        reset4("s1 reset");
        bit4("s1 b1", 1'b1, S1, 1'b0, 8'd0);
        bit4("s1 b2", 1'b0, S2, 1'b0, 8'd0);
        bit4("s1 b3", 1'b1, S3, 1'b0, 8'd0);
        bit4("s1 b4", 1'b1, S1, 1'b1, 8'd1);
        idle4("s1 after", 1, S1, 8'd1);

        // Overlapping stream 1011011
        reset4("s2o reset");
        bit4("s2o b1", 1'b1, S1, 1'b0, 8'd0);
        bit4("s2o b2", 1'b0, S2, 1'b0, 8'd0);
        bit4("s2o b3", 1'b1, S3, 1'b0, 8'd0);
        bit4("s2o b4", 1'b1, S1, 1'b1, 8'd1);
        bit4("s2o b5", 1'b0, S2, 1'b0, 8'd1);
        bit4("s2o b6", 1'b1, S3, 1'b0, 8'd1);
        bit4("s2o b7", 1'b1, S1, 1'b1, 8'd2);
        idle4("s2o after", 1, S1, 8'd2);

        // Same stream, non-overlapping
        bus4.overlap_en = 1'b0;
        reset4("s2n reset");
        bit4("s2n b1", 1'b1, S1, 1'b0, 8'd0);
        bit4("s2n b2", 1'b0, S2, 1'b0, 8'd0);
        bit4("s2n b3", 1'b1, S3, 1'b0, 8'd0);
        bit4("s2n b4", 1'b1, S0, 1'b1, 8'd1);
        bit4("s2n b5", 1'b0, S0, 1'b0, 8'd1);
        bit4("s2n b6", 1'b1, S1, 1'b0, 8'd1);
        bit4("s2n b7", 1'b1, S1, 1'b0, 8'd1);
        idle4("s2n after", 1, S1, 8'd1);

        // Gaps with random x while x_valid is low
        bus4.overlap_en = 1'b1;
        reset4("s3 reset");
        bit4("s3 b1", 1'b1, S1, 1'b0, 8'd0);
        idle4("s3 gap1", 2, S1, 8'd0);
        bit4("s3 b2", 1'b0, S2, 1'b0, 8'd0);
        idle4("s3 gap2", 1, S2, 8'd0);
        bit4("s3 b3", 1'b1, S3, 1'b0, 8'd0);
        idle4("s3 gap3", 3, S3, 8'd0);
        bit4("s3 b4", 1'b1, S1, 1'b1, 8'd1);
        idle4("s3 after", 1, S1, 8'd1);

        // Load a new pattern mid-sequence
        reset4("s4 reset");
        bit4("s4 b1", 1'b1, S1, 1'b0, 8'd0);
        bit4("s4 b2", 1'b0, S2, 1'b0, 8'd0);
        bit4("s4 b3", 1'b1, S3, 1'b0, 8'd0);
        bit4("s4 b4", 1'b1, S1, 1'b1, 8'd1);
        bit4("s4 b5", 1'b0, S2, 1'b0, 8'd1);
        applyStimulus("s4 load", 1'b0, 1'b1, 1'b1, 1'b1, 4'b0110, S0, 1'b0, 8'd1, exp_err);
        bit4("s4 p1", 1'b0, S1, 1'b0, 8'd1);
        bit4("s4 p2", 1'b1, S2, 1'b0, 8'd1);
        bit4("s4 p3", 1'b1, S3, 1'b0, 8'd1);
        bit4("s4 p4", 1'b0, S1, 1'b1, 8'd2);

        // Reset from S3 restores the reset pattern and clears the counter
        bit4("s6 p5", 1'b1, S2, 1'b0, 8'd2);
        bit4("s6 p6", 1'b1, S3, 1'b0, 8'd2);
        applyStimulus("s6 reset", 1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, S0, 1'b0, 8'd0, 1'b0);
        bit4("s6 b1", 1'b1, S1, 1'b0, 8'd0);
        bit4("s6 b2", 1'b0, S2, 1'b0, 8'd0);
        bit4("s6 b3", 1'b1, S3, 1'b0, 8'd0);
        bit4("s6 b4", 1'b1, S1, 1'b1, 8'd1);

`ifdef ONEHOT_CHECK_EN
        // Illegal state injection: recovery to S0 with sticky error flag
        @(negedge clk);
        bus4.x_valid = 1'b0;
        bus4.load    = 1'b0;
        force dut4.state_q = 4'b0101;
        #1;
        release dut4.state_q;
        q4.push_back('{"s6 onehot recover", S0, 1'b0, 8'd1, 1'b1});
        exp_err = 1'b1;
        idle4("s6 err sticky", 2, S0, 8'd1);
        exp_err = 1'b0;
        reset4("s6 err clear");
`else
        idle4("s6 no err", 1, S1, 8'd1);
`endif

        // 2-bit pattern 11: back-to-back pulses and counter saturation
        applyStimulus2("s5 reset", 1'b1, 1'b0, 1'b0, T0, 1'b0, 2'd0);
        applyStimulus2("s5 b1", 1'b0, 1'b1, 1'b1, T1, 1'b0, 2'd0);
        applyStimulus2("s5 b2", 1'b0, 1'b1, 1'b1, T1, 1'b1, 2'd1);
        applyStimulus2("s5 b3", 1'b0, 1'b1, 1'b1, T1, 1'b1, 2'd2);
        applyStimulus2("s5 b4", 1'b0, 1'b1, 1'b1, T1, 1'b1, 2'd3);
        applyStimulus2("s5 b5", 1'b0, 1'b1, 1'b1, T1, 1'b1, 2'd3);
        applyStimulus2("s5 b6", 1'b0, 1'b1, 1'b1, T1, 1'b1, 2'd3);
        applyStimulus2("s5 idle", 1'b0, 1'b0, 1'b1, T1, 1'b0, 2'd3);
        applyStimulus2("s5 zero", 1'b0, 1'b1, 1'b0, T0, 1'b0, 2'd3);

        // Drain: every queued expectation must have been consumed
        @(negedge clk);
        bus2.x_valid = 1'b0;
        bus4.x_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        if ((q4.size() != 0) || (q2.size() != 0)) begin
            errors++;
            checks++;
            $display("[TB] FAIL drain: got %0d/%0d pending, want 0/0", q4.size(), q2.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
